centroid_div_scheduler: RTL and testbench

Frame-level scheduler for the multi-point tracker. During active video it accumulates per-group run midpoints (H/V sums and counts) from the point-grouping stage. At each frame end it runs one shared sequential divider across all active groups to form the centroids. It then publishes up to four points to the D8M/VGA overlay and UART side, with a one-cycle done pulse. This replaces per-group combinational division, which does not close timing on the DE10-Nano.

---
 rtl/centroid_div_scheduler_pkg.sv | 22 ++
 rtl/centroid_div_scheduler_divider.sv | 79 +++++++
 rtl/centroid_div_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_centroid_div_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_div_scheduler_pkg.sv
// Shared definitions for the tracker's centroid scheduler and the point-grouping stage.
package centroid_div_scheduler_pkg;

  localparam int SUM_W_DEF = 24;
  localparam int CNT_W_DEF = 8;
  localparam int NPOINT    = 4;
  localparam int PT_W      = 16;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_DIVIDE  = 2'd1,
    ST_PUBLISH = 2'd2
  } sched_state_t;

  localparam logic AX_H = 1'b0;
  localparam logic AX_V = 1'b1;

  function automatic logic [2:0] clamp_groups(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/centroid_div_scheduler_divider.sv
// Restoring sequential divider: one quotient bit per cycle, done in the 25th cycle counting the start cycle.
module seq_divider
  import centroid_div_scheduler_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int IW = $clog2(SUM_W);

  logic             busy;
  logic [IW-1:0]    iter;
  logic [CNT_W-1:0] dvs;
  logic [CNT_W-1:0] rem;
  logic [SUM_W-1:0] q;

  logic [CNT_W-1:0] rem_in;
  logic [CNT_W-1:0] d_cur;
  logic [CNT_W-1:0] rem_nxt;
  logic             bit_in;
  logic             q_bit;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;

  // The load cycle already resolves the top quotient bit, so 23 more steps finish the job.
  always_comb begin
    rem_in  = busy ? rem : '0;
    d_cur   = busy ? dvs : divisor;
    bit_in  = busy ? q[SUM_W-1] : dividend[SUM_W-1];
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, d_cur};
    q_bit   = (trial >= {1'b0, d_cur});
    rem_nxt = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= 1'b0;
      done <= 1'b0;
      iter <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          iter <= IW'(SUM_W - 1);
        end
      end else begin
        iter <= iter - 1'b1;
        if (iter == IW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!busy && start) begin
      dvs <= divisor;
      rem <= rem_nxt;
      q   <= {dividend[SUM_W-2:0], q_bit};
    end else if (busy) begin
      rem <= rem_nxt;
      q   <= {q[SUM_W-2:0], q_bit};
    end
  end

  assign quotient = q;

endmodule

// File: rtl/centroid_div_scheduler.sv
// Frame-level centroid scheduler: accumulate run midpoints, divide once per frame end, publish 4 points.
module centroid_div_scheduler
  import centroid_div_scheduler_pkg::*;
#(
  parameter int NGROUP = 4,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VGA_VS,
  input  logic        i_ACC_VALID,
  input  logic [1:0]  i_ACC_GROUP,
  input  logic [15:0] i_ACC_H,
  input  logic [15:0] i_ACC_V,
  input  logic [2:0]  i_GROUP_CNT,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic [15:0] o_POINTS_H_0,
  output logic [15:0] o_POINTS_H_1,
  output logic [15:0] o_POINTS_H_2,
  output logic [15:0] o_POINTS_H_3,
  output logic [15:0] o_POINTS_V_0,
  output logic [15:0] o_POINTS_V_1,
  output logic [15:0] o_POINTS_V_2,
  output logic [15:0] o_POINTS_V_3,
  output logic [2:0]  o_POINTS_NUM,
  output logic [7:0]  o_DROP_CNT
);

  sched_state_t state, state_nxt;

  logic             rvs;
  logic             frame_end;
  logic [SUM_W-1:0] sum_h [NGROUP];
  logic [SUM_W-1:0] sum_v [NGROUP];
  logic [CNT_W-1:0] cnt   [NGROUP];
  logic [PT_W-1:0]  res_h [NGROUP];
  logic [PT_W-1:0]  res_v [NGROUP];
  logic [PT_W-1:0]  pts_h [NPOINT];
  logic [PT_W-1:0]  pts_v [NPOINT];
  logic [2:0]       n_grp;
  logic [2:0]       n_points;
  logic [1:0]       g;
  logic             axis;
  logic             div_run;
  logic             done_r;
  logic [7:0]       drop_cnt;

  logic             busy;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_q;
  logic [SUM_W-1:0] div_dividend;
  logic             cnt_zero;
  logic             axis_end;
  logic             last_axis;
  logic [PT_W-1:0]  axis_res;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [15:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W+1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign frame_end = rvs && !VGA_VS;

  always_comb begin
    cnt_zero     = (cnt[g] == '0);
    axis_end     = (state == ST_DIVIDE) && (div_run ? div_done : cnt_zero);
    axis_res     = div_run ? div_q[PT_W-1:0] : '0;
    last_axis    = (axis == AX_V) && ({1'b0, g} == n_grp - 3'd1);
    div_dividend = (axis == AX_H) ? sum_h[g] : sum_v[g];
    drop_inc     = {1'b0, i_ACC_VALID} + {1'b0, frame_end};
    drop_sum     = {1'b0, drop_cnt} + 9'(drop_inc);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: begin
        if (frame_end)
          state_nxt = (clamp_groups(i_GROUP_CNT) == 3'd0) ? ST_PUBLISH : ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (axis_end && last_axis) state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: state_nxt = ST_ACCUM;
      default:    state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    busy      = (state != ST_ACCUM);
    div_start = (state == ST_DIVIDE) && !div_run && !cnt_zero;
  end

  // Walk H then V for each group; zero-count groups skip the divider in one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvs      <= 1'b0;
      n_grp    <= '0;
      g        <= '0;
      axis     <= AX_H;
      div_run  <= 1'b0;
      done_r   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rvs    <= VGA_VS;
      done_r <= (state == ST_PUBLISH);
      if (state == ST_ACCUM && frame_end) begin
        n_grp   <= clamp_groups(i_GROUP_CNT);
        g       <= '0;
        axis    <= AX_H;
        div_run <= 1'b0;
      end
      if (div_start) div_run <= 1'b1;
      if (axis_end) begin
        div_run <= 1'b0;
        if (axis == AX_H) begin
          axis <= AX_V;
        end else begin
          axis <= AX_H;
          g    <= g + 2'd1;
        end
      end
      if (busy) drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || state == ST_PUBLISH) begin
      for (int i = 0; i < NGROUP; i++) begin
        sum_h[i] <= '0;
        sum_v[i] <= '0;
        cnt[i]   <= '0;
      end
    end else if (state == ST_ACCUM && i_ACC_VALID) begin
      sum_h[i_ACC_GROUP] <= sat_add(sum_h[i_ACC_GROUP], i_ACC_H);
      sum_v[i_ACC_GROUP] <= sat_add(sum_v[i_ACC_GROUP], i_ACC_V);
      if (cnt[i_ACC_GROUP] != '1) cnt[i_ACC_GROUP] <= cnt[i_ACC_GROUP] + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NGROUP; i++) begin
        res_h[i] <= '0;
        res_v[i] <= '0;
      end
    end else if (axis_end) begin
      if (axis == AX_H) res_h[g] <= axis_res;
      else              res_v[g] <= axis_res;
    end
  end

  // Output registers only move on PUBLISH, so they hold steady between done pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NPOINT; i++) begin
        pts_h[i] <= '0;
        pts_v[i] <= '0;
      end
      n_points <= '0;
    end else if (state == ST_PUBLISH) begin
      for (int i = 0; i < NPOINT; i++) begin
        pts_h[i] <= (3'(i) < n_grp) ? res_h[i] : '0;
        pts_v[i] <= (3'(i) < n_grp) ? res_v[i] : '0;
      end
      n_points <= n_grp;
    end
  end

  seq_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .CLK     (CLK),
    .RST     (RST),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (cnt[g]),
    .quotient(div_q),
    .done    (div_done)
  );

  assign o_BUSY       = busy;
  assign o_DONE       = done_r;
  assign o_POINTS_H_0 = pts_h[0];
  assign o_POINTS_H_1 = pts_h[1];
  assign o_POINTS_H_2 = pts_h[2];
  assign o_POINTS_H_3 = pts_h[3];
  assign o_POINTS_V_0 = pts_v[0];
  assign o_POINTS_V_1 = pts_v[1];
  assign o_POINTS_V_2 = pts_v[2];
  assign o_POINTS_V_3 = pts_v[3];
  assign o_POINTS_NUM = n_points;
  assign o_DROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Scoreboard bench for centroid_div_scheduler: frame stimulus queues expected publishes, a monitor checks each done.
module tb_centroid_div_scheduler;

  typedef struct packed {
    logic [3:0][15:0] h;
    logic [3:0][15:0] v;
    logic [2:0]       num;
    logic [7:0]       drop;
    logic [31:0]      cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VGA_VS;
  logic        i_ACC_VALID;
  logic [1:0]  i_ACC_GROUP;
  logic [15:0] i_ACC_H;
  logic [15:0] i_ACC_V;
  logic [2:0]  i_GROUP_CNT;
  logic        o_BUSY;
  logic        o_DONE;
  logic [15:0] o_POINTS_H_0, o_POINTS_H_1, o_POINTS_H_2, o_POINTS_H_3;
  logic [15:0] o_POINTS_V_0, o_POINTS_V_1, o_POINTS_V_2, o_POINTS_V_3;
  logic [2:0]  o_POINTS_NUM;
  logic [7:0]  o_DROP_CNT;

  logic [15:0] ph [4];
  logic [15:0] pv [4];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];

  centroid_div_scheduler dut (
    .CLK         (CLK),
    .RST         (RST),
    .VGA_VS      (VGA_VS),
    .i_ACC_VALID (i_ACC_VALID),
    .i_ACC_GROUP (i_ACC_GROUP),
    .i_ACC_H     (i_ACC_H),
    .i_ACC_V     (i_ACC_V),
    .i_GROUP_CNT (i_GROUP_CNT),
    .o_BUSY      (o_BUSY),
    .o_DONE      (o_DONE),
    .o_POINTS_H_0(o_POINTS_H_0),
    .o_POINTS_H_1(o_POINTS_H_1),
    .o_POINTS_H_2(o_POINTS_H_2),
    .o_POINTS_H_3(o_POINTS_H_3),
    .o_POINTS_V_0(o_POINTS_V_0),
    .o_POINTS_V_1(o_POINTS_V_1),
    .o_POINTS_V_2(o_POINTS_V_2),
    .o_POINTS_V_3(o_POINTS_V_3),
    .o_POINTS_NUM(o_POINTS_NUM),
    .o_DROP_CNT  (o_DROP_CNT)
  );

  assign ph[0] = o_POINTS_H_0;
  assign ph[1] = o_POINTS_H_1;
  assign ph[2] = o_POINTS_H_2;
  assign ph[3] = o_POINTS_H_3;
  assign pv[0] = o_POINTS_V_0;
  assign pv[1] = o_POINTS_V_1;
  assign pv[2] = o_POINTS_V_2;
  assign pv[3] = o_POINTS_V_3;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] h0, h1, h2, h3, v0, v1, v2, v3,
                              input logic [2:0] num, input logic [7:0] drop);
    exp_t e;
    e.h    = {h3, h2, h1, h0};
    e.v    = {v3, v2, v1, v0};
    e.num  = num;
    e.drop = drop;
    e.cyc  = '0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (o_DONE === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("point_h%0d", i), 32'(ph[i]), 32'(e.h[i]));
          chk($sformatf("point_v%0d", i), 32'(pv[i]), 32'(e.v[i]));
        end
        chk("points_num", 32'(o_POINTS_NUM), 32'(e.num));
        chk("drop_cnt", 32'(o_DROP_CNT), 32'(e.drop));
        chk("busy_at_done", 32'(o_BUSY), 32'd0);
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_h%0d", tag, i), 32'(ph[i]), 32'd0);
      chk($sformatf("%s_v%0d", tag, i), 32'(pv[i]), 32'd0);
    end
    chk({tag, "_num"}, 32'(o_POINTS_NUM), 32'd0);
    chk({tag, "_done"}, 32'(o_DONE), 32'd0);
    chk({tag, "_busy"}, 32'(o_BUSY), 32'd0);
    chk({tag, "_drop"}, 32'(o_DROP_CNT), 32'd0);
  endtask

  task automatic put_sample(input logic [1:0] grp, input logic [15:0] h, input logic [15:0] v);
    @(negedge CLK);
    i_ACC_VALID = 1'b1;
    i_ACC_GROUP = grp;
    i_ACC_H     = h;
    i_ACC_V     = v;
  endtask

  // Frame end lands on this negedge's cycle t; publish is expected at t + 2 + division cost.
  task automatic frame_end(input logic [2:0] n, input int cost, input exp_t e, input bit expect_done,
                           input bit with_sample, input logic [1:0] grp,
                           input logic [15:0] h, input logic [15:0] v);
    exp_t x;
    @(negedge CLK);
    i_ACC_VALID = with_sample;
    i_ACC_GROUP = grp;
    i_ACC_H     = h;
    i_ACC_V     = v;
    VGA_VS      = 1'b0;
    i_GROUP_CNT = n;
    x           = e;
    x.cyc       = 32'(cyc) + 32'(cost) + 32'd2;
    if (expect_done) sb.push_back(x);
    @(negedge CLK);
    VGA_VS      = 1'b1;
    i_ACC_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    RST         = 1'b1;
    VGA_VS      = 1'b1;
    i_ACC_VALID = 1'b0;
    i_ACC_GROUP = '0;
    i_ACC_H     = '0;
    i_ACC_V     = '0;
    i_GROUP_CNT = '0;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // No groups: straight to publish
    frame_end(3'd0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    wait_idle(50);

    // Basic centroid: H 60/3 = 20, V 16/3 = 5
    put_sample(2'd0, 16'd10, 16'd5);
    put_sample(2'd0, 16'd20, 16'd5);
    put_sample(2'd0, 16'd30, 16'd6);
    frame_end(3'd1, 50, mk(20, 0, 0, 0, 5, 0, 0, 0, 3'd1, 8'd0), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    wait_idle(300);

    // Four groups, last sample coincides with frame end: H (400g+10)/4 = 100g+2
    for (int gi = 0; gi < 4; gi++)
      for (int k = 1; k <= 4; k++)
        if (!(gi == 3 && k == 4)) put_sample(2'(gi), 16'(100 * gi + k), 16'(50 + gi));
    frame_end(3'd4, 200, mk(2, 102, 202, 302, 50, 51, 52, 53, 3'd4, 8'd0), 1'b1,
              1'b1, 2'd3, 16'd304, 16'd53);
    wait_idle(300);

    // Empty group 1: H 16/2 = 8, V 7/2 = 3
    put_sample(2'd0, 16'd7, 16'd3);
    put_sample(2'd0, 16'd9, 16'd4);
    frame_end(3'd2, 52, mk(8, 0, 0, 0, 3, 0, 0, 0, 3'd2, 8'd0), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    wait_idle(300);

    // Busy drop: 3 samples and one frame end during DIVIDE
    put_sample(2'd0, 16'd40, 16'd8);
    put_sample(2'd0, 16'd50, 16'd8);
    frame_end(3'd1, 50, mk(45, 0, 0, 0, 8, 0, 0, 0, 3'd1, 8'd4), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    repeat (4) @(negedge CLK);
    put_sample(2'd0, 16'd9000, 16'd9000);
    put_sample(2'd0, 16'd9000, 16'd9000);
    put_sample(2'd0, 16'd9000, 16'd9000);
    @(negedge CLK);
    i_ACC_VALID = 1'b0;
    VGA_VS      = 1'b0;
    @(negedge CLK);
    VGA_VS = 1'b1;
    wait_idle(300);
    repeat (60) @(negedge CLK);

    // Saturation: sum 0xFFFFFF / 255 = 0x10101 -> 0x0101; V 2100/255 = 8; count clamped to 4 groups
    for (int k = 0; k < 300; k++) put_sample(2'd0, 16'hFFFF, 16'd7);
    frame_end(3'd6, 56, mk(16'h0101, 0, 0, 0, 8, 0, 0, 0, 3'd4, 8'd4), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    wait_idle(300);

    // Reset mid-DIVIDE: no publish, outputs cleared, next frame clean
    put_sample(2'd0, 16'd100, 16'd100);
    frame_end(3'd1, 50, mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0), 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_zero("midreset");
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    put_sample(2'd2, 16'd1000, 16'd500);
    put_sample(2'd2, 16'd1002, 16'd501);
    frame_end(3'd3, 54, mk(0, 0, 1001, 0, 0, 0, 500, 0, 3'd3, 8'd0), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    wait_idle(300);

    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
